spc_llr_gather: RTL and testbench
=================================

# spc_llr_gather

Upstream feeder for the single-parity-check (SPC) node decoder. It accepts node LLRs from the LLR memory read port, 4 per beat, and saturates each one to the internal LLR width. It assembles 16-LLR frames into a two-entry ping-pong buffer and presents each complete frame as a valid/ready process-unit LLR bus. It sits between the LLR memory read mux and the combinational SPC decision logic, isolating memory read timing from the decoder.

## Interface
- LLR_IN_W, 8: signed width of each LLR as read from memory
- LLR_W, 6: signed internal LLR width on the output bus; must satisfy LLR_W <= LLR_IN_W
- LANES, 4: LLRs per input beat
- NUM, 16: LLRs per frame; NUM/LANES beats per frame (4)

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous; discards the partial frame and both buffered frames
- in_valid  in  1  input beat valid
- in_ready  out  1  gather can accept a beat
- in_llr  in  LANES*LLR_IN_W  lane 0 in the MSBs
- out_valid  out  1  complete frame available
- out_ready  in  1  consumer takes the frame
- out_llr  out  NUM*LLR_W  LLR i at bits [NUM*LLR_W-1-i*LLR_W -: LLR_W]; LLR 0 in the MSBs
- sat_cnt  out  16  saturation event counter (see Configuration)

## Operation
- Beat k of a frame (k=0..3) carries LLRs 4k..4k+3; lane j maps to LLR 4k+j.
- Saturation per lane, MAX = 2^(LLR_W-1)-1 (31):
  - v > MAX -> MAX
  - v < -MAX -> -MAX
  - otherwise v truncated to LLR_W bits
  - The output range is symmetric. -2^(LLR_W-1) is never produced, so downstream two's-complement abs cannot overflow.
- Two frame buffers, B0 and B1, with write pointer wp, read pointer rp, per-buffer full flags, and beat counter bc (2 bits).
- Accept: in_valid & in_ready writes 4 saturated LLRs into buffer wp at slot bc, then bc++.
  - On bc==3 accept: full[wp] is set, wp toggles, bc wraps to 0.
- in_ready = !full[wp]. It is taken from registers only, with no combinational path from out_ready.
- out_valid = full[rp]; out_llr = buffer[rp].
  - On out_valid & out_ready: full[rp] clears and rp toggles.
- Simultaneous frame completion and frame consumption in the same cycle are both honoured. They touch different buffers; when both are full, in_ready is 0, so completion cannot occur.
- out_llr stays stable while out_valid=1 and out_ready=0.
- flush has priority over all accepts and consumes. It clears full[1:0], wp, rp and bc; buffer data is don't-care.
- Mid-frame in_valid drop: bc holds and the frame resumes on the next accepted beat. There is no timeout.

## Timing
- Reset values: in_ready=1, out_valid=0, out_llr=0, sat_cnt=0, bc=0, wp=rp=0.
- Latency: out_valid rises in the cycle after the 4th beat is accepted (1-cycle registered).
- Throughput: with out_ready held at 1, in_valid is accepted every cycle, giving one frame per 4 cycles with no bubbles.
- Backpressure: with out_ready=0, at most 2 frames (8 beats) are accepted, then in_ready=0 from the cycle after the 8th accept.
- flush in cycle t: in the next cycle, out_valid=0 and in_ready=1. Accept and consume handshakes in cycle t are ignored.
- rst asserted mid-frame: all state clears immediately (asynchronous); the first beat after release is beat 0.

## Configuration
- SPC_GATHER_SAT_CNT_EN defined:
  - sat_cnt adds the number of clipped lanes (0..4) in each accepted beat.
  - The counter saturates at 16'hFFFF.
  - It is cleared by rst and by flush.
- SPC_GATHER_SAT_CNT_EN undefined: sat_cnt is tied to 16'h0 and no counter logic is built.

## Test plan
- Single frame: 4 beats, LLR i = i-8 (in range), out_ready=1 -> out_valid one cycle after beat 3; out_llr LLR0=-8 … LLR15=7; sat_cnt=0.
- Saturation: lanes {+100, -100, -32, +31}, all in beat 0 -> LLR0..3 = {31, -31, -31, 31}. With the macro, sat_cnt=3; without it, sat_cnt=0.
- Backpressure: out_ready=0 and 12 beats offered -> exactly 8 accepted and in_ready=0. Then raising out_ready drains frame A, then frame B, in order with data intact, and in_ready returns to 1 one cycle after the first consume.
- Streaming: in_valid=1 and out_ready=1 for 40 cycles -> 10 frames, no in_ready deassertion, out_valid pulses every 4 cycles.
- Flush: flush asserted after 2 beats of frame 0 with frame 1 buffered -> next cycle out_valid=0, in_ready=1; the next 4 beats form a fresh frame at LLR slots 0..15.
- Async reset mid-frame: rst asserted for 1 ns between edges after beat 1 -> outputs are at reset values immediately; a new 4-beat frame after release is output correctly.

Source files
------------

// File: rtl/spc_llr_gather.sv
// spc_llr_gather: gathers 4-LLR beats from the LLR memory read port into
// 16-LLR frames, saturating each LLR to a symmetric internal range, and
// presents complete frames on a valid/ready bus through a two-entry
// ping-pong buffer.
// Optional feature macro: SPC_GATHER_SAT_CNT_EN (saturation event counter).
module spc_llr_gather #(
    parameter int LLR_IN_W = 8,
    parameter int LLR_W    = 6,
    parameter int LANES    = 4,
    parameter int NUM      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*LLR_IN_W-1:0] in_llr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM*LLR_W-1:0]      out_llr,
    output logic [15:0]               sat_cnt
);

    localparam int BEATS = NUM / LANES;
    localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic signed [LLR_IN_W-1:0] MAX_IN = LLR_IN_W'((1 << (LLR_W - 1)) - 1);
    localparam logic signed [LLR_IN_W-1:0] MIN_IN = -MAX_IN;

    // True when the input LLR lies outside the symmetric output range.
    function automatic logic is_clip(input logic signed [LLR_IN_W-1:0] v);
        return (v > MAX_IN) || (v < MIN_IN);
    endfunction

    // Symmetric saturation: -2^(LLR_W-1) is never produced, so a downstream
    // two's-complement abs of the result cannot overflow.
    function automatic logic signed [LLR_W-1:0] sat_llr(input logic signed [LLR_IN_W-1:0] v);
        logic signed [LLR_W-1:0] r;
        if (v > MAX_IN)
            r = MAX_IN[LLR_W-1:0];
        else if (v < MIN_IN)
            r = MIN_IN[LLR_W-1:0];
        else
            r = v[LLR_W-1:0];
        return r;
    endfunction

    // Stage p0: raw lanes unpacked from the read port and saturated.
    logic signed [LLR_IN_W-1:0] lane_raw_p0 [LANES];
    logic signed [LLR_W-1:0]    lane_p0     [LANES];

    // Stage p1: ping-pong frame buffers with one valid flag per buffer.
    logic signed [LLR_W-1:0] frame_p1 [2][BEATS][LANES];
    logic [1:0]              vld_p1;
    logic                    wp_q;
    logic                    rp_q;
    logic [BC_W-1:0]         bc_q;

    logic acc;
    logic cons;
    logic last_beat;

    assign in_ready  = !vld_p1[wp_q];
    assign out_valid = vld_p1[rp_q];
    assign acc       = in_valid && in_ready && !flush;
    assign cons      = out_valid && out_ready && !flush;
    assign last_beat = (bc_q == BC_W'(BEATS - 1));

    // Unpack the beat (lane 0 in the MSBs) and saturate every lane.
    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            lane_raw_p0[j] = in_llr[LANES*LLR_IN_W-1-j*LLR_IN_W -: LLR_IN_W];
            lane_p0[j]     = sat_llr(lane_raw_p0[j]);
        end
    end

    // Control: beat counter, ping-pong pointers and buffer-full flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 2'b00;
            wp_q   <= 1'b0;
            rp_q   <= 1'b0;
            bc_q   <= '0;
        end else if (flush) begin
            vld_p1 <= 2'b00;
            wp_q   <= 1'b0;
            rp_q   <= 1'b0;
            bc_q   <= '0;
        end else begin
            // Completion and consumption never target the same buffer.
            if (cons) begin
                vld_p1[rp_q] <= 1'b0;
                rp_q         <= ~rp_q;
            end
            if (acc) begin
                if (last_beat) begin
                    vld_p1[wp_q] <= 1'b1;
                    wp_q         <= ~wp_q;
                    bc_q         <= '0;
                end else begin
                    bc_q <= bc_q + 1'b1;
                end
            end
        end
    end

    // Data: write the saturated beat into the current buffer slot.
    always_ff @(posedge clk) begin
        if (acc) begin
            for (int j = 0; j < LANES; j++)
                frame_p1[wp_q][bc_q][j] <= lane_p0[j];
        end
    end

    // Present the read buffer; zero when no frame is held.
    always_comb begin
        out_llr = '0;
        if (out_valid) begin
            for (int b = 0; b < BEATS; b++)
                for (int j = 0; j < LANES; j++)
                    out_llr[NUM*LLR_W-1-(b*LANES+j)*LLR_W -: LLR_W] = frame_p1[rp_q][b][j];
        end
    end

`ifdef SPC_GATHER_SAT_CNT_EN
    localparam int CNT_W = $clog2(LANES + 1);

    logic [CNT_W-1:0] clip_cnt_p0;
    logic [16:0]      sat_sum;
    logic [15:0]      sat_q;

    // Count clipped lanes in the current beat and form the saturating sum.
    always_comb begin
        clip_cnt_p0 = '0;
        for (int j = 0; j < LANES; j++)
            clip_cnt_p0 = clip_cnt_p0 + CNT_W'(is_clip(lane_raw_p0[j]));
        sat_sum = {1'b0, sat_q} + 17'(clip_cnt_p0);
    end

    // Saturation event counter, sticky at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sat_q <= 16'h0;
        else if (flush)
            sat_q <= 16'h0;
        else if (acc)
            sat_q <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end

    assign sat_cnt = sat_q;
`else
    assign sat_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_spc_llr_gather.sv
// tb_spc_llr_gather: randomized and directed stimulus for spc_llr_gather,
// checked every cycle against a queue-based frame model plus literal checks.
module tb_spc_llr_gather;

    localparam int LLR_IN_W = 8;
    localparam int LLR_W    = 6;
    localparam int LANES    = 4;
    localparam int NUM      = 16;
    localparam int OW       = NUM * LLR_W;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      flush;
    logic                      in_valid;
    logic                      in_ready;
    logic [LANES*LLR_IN_W-1:0] in_llr;
    logic                      out_valid;
    logic                      out_ready;
    logic [OW-1:0]             out_llr;
    logic [15:0]               sat_cnt;

    int tests = 0;
    int fails = 0;

    spc_llr_gather #(.LLR_IN_W(LLR_IN_W), .LLR_W(LLR_W), .LANES(LANES), .NUM(NUM)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_llr(in_llr),
        .out_valid(out_valid), .out_ready(out_ready), .out_llr(out_llr),
        .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int          part[$];
    logic [OW-1:0] fq[$];
    int          sat_m = 0;
    bit          m_acc, m_cons;
    logic signed [7:0] m_b;
    int          m_v, m_s;
    logic [OW-1:0] m_fr;

    always @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            part.delete();
            fq.delete();
            sat_m = 0;
        end else begin
            m_acc  = in_valid && (fq.size() < 2);
            m_cons = out_ready && (fq.size() > 0);
            if (m_cons) void'(fq.pop_front());
            if (m_acc) begin
                for (int j = 0; j < LANES; j++) begin
                    m_b = in_llr[LANES*8-1-j*8 -: 8];
                    m_v = int'(m_b);
                    if (m_v > 31) m_s = 31;
                    else if (m_v < -31) m_s = -31;
                    else m_s = m_v;
                    if (m_s != m_v && sat_m < 65535) sat_m++;
                    part.push_back(m_s);
                end
                if (part.size() == NUM) begin
                    m_fr = '0;
                    for (int i = 0; i < NUM; i++)
                        m_fr[OW-1-i*LLR_W -: LLR_W] = 6'(part[i]);
                    fq.push_back(m_fr);
                    part.delete();
                end
            end
        end
    end

    function automatic logic [15:0] exp_sat();
`ifdef SPC_GATHER_SAT_CNT_EN
        return 16'(sat_m);
`else
        return 16'h0;
`endif
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare process: outputs are register-driven, checked on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready", 128'(in_ready), 128'(fq.size() < 2));
            check("out_valid", 128'(out_valid), 128'(fq.size() > 0));
            check("out_llr", 128'(out_llr), 128'((fq.size() > 0) ? fq[0] : '0));
            check("sat_cnt", 128'(sat_cnt), 128'(exp_sat()));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int l0, input int l1, input int l2, input int l3);
        in_valid = 1'b1;
        in_llr   = {8'(l0), 8'(l1), 8'(l2), 8'(l3)};
        tick();
    endtask

    int nacc, drops, nv;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_llr = '0;
        #12;
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_llr", 128'(out_llr), 128'(0));
        check("rst_sat_cnt", 128'(sat_cnt), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Single in-range frame, LLR i = i-8.
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) beat(4*k-8, 4*k-7, 4*k-6, 4*k-5);
        in_valid = 1'b0;
        check("single_valid", 128'(out_valid), 128'(1));
        check("single_llr0", 128'(out_llr[OW-1 -: 6]), 128'(6'h38));
        check("single_llr15", 128'(out_llr[5:0]), 128'(6'h07));
        check("single_sat", 128'(sat_cnt), 128'(0));
        tick();

        // Saturation in beat 0.
        out_ready = 1'b0;
        beat(100, -100, -32, 31);
        for (int k = 1; k < 4; k++) beat(0, 0, 0, 0);
        in_valid = 1'b0;
        check("sat_llr0", 128'(out_llr[OW-1 -: 6]), 128'(6'h1F));
        check("sat_llr1", 128'(out_llr[OW-7 -: 6]), 128'(6'h21));
        check("sat_llr2", 128'(out_llr[OW-13 -: 6]), 128'(6'h21));
        check("sat_llr3", 128'(out_llr[OW-19 -: 6]), 128'(6'h1F));
`ifdef SPC_GATHER_SAT_CNT_EN
        check("sat_cnt3", 128'(sat_cnt), 128'(3));
`else
        check("sat_cnt0", 128'(sat_cnt), 128'(0));
`endif
        out_ready = 1'b1;
        tick();

        // Backpressure: 12 beats offered, 8 accepted.
        out_ready = 1'b0;
        nacc = 0;
        for (int n = 0; n < 12; n++) begin
            in_valid = 1'b1;
            in_llr   = $urandom;
            if (in_ready) nacc++;
            tick();
        end
        in_valid = 1'b0;
        check("bp_accepted", 128'(nacc), 128'(8));
        check("bp_in_ready", 128'(in_ready), 128'(0));
        out_ready = 1'b1;
        tick();
        check("bp_ready_back", 128'(in_ready), 128'(1));
        check("bp_frame_b", 128'(out_valid), 128'(1));
        tick();
        check("bp_drained", 128'(out_valid), 128'(0));

        // Streaming, 40 cycles.
        drops = 0; nv = 0;
        for (int n = 0; n < 40; n++) begin
            in_valid = 1'b1;
            in_llr   = $urandom;
            tick();
            if (!in_ready) drops++;
            if (out_valid) nv++;
        end
        in_valid = 1'b0;
        check("stream_drops", 128'(drops), 128'(0));
        check("stream_frames", 128'(nv), 128'(10));
        tick();

        // Flush with one frame buffered and a partial frame in progress.
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) beat(k, k, k, k);
        flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("flush_valid", 128'(out_valid), 128'(0));
        check("flush_ready", 128'(in_ready), 128'(1));
        for (int k = 0; k < 4; k++) beat(10+4*k, 11+4*k, 12+4*k, 13+4*k);
        in_valid = 1'b0;
        check("flush_new_valid", 128'(out_valid), 128'(1));
        check("flush_new_llr0", 128'(out_llr[OW-1 -: 6]), 128'(6'h0A));
        check("flush_new_llr15", 128'(out_llr[5:0]), 128'(6'h19));
        out_ready = 1'b1;
        tick();

        // Asynchronous reset mid-frame with a frame buffered.
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) beat(-k, k, 2*k, 3*k);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_in_ready", 128'(in_ready), 128'(1));
        check("arst_out_valid", 128'(out_valid), 128'(0));
        check("arst_out_llr", 128'(out_llr), 128'(0));
        check("arst_sat_cnt", 128'(sat_cnt), 128'(0));
        rst = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) beat(-5-k, 1, 2, 3);
        in_valid = 1'b0;
        check("arst_new_llr0", 128'(out_llr[OW-1 -: 6]), 128'(6'h3B));
        out_ready = 1'b1;
        tick();

        // Randomized traffic with occasional flushes.
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = $urandom_range(0, 1) == 1;
            flush     = ($urandom_range(0, 63) == 0);
            in_llr    = $urandom;
            tick();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
